midi_mono_voice_ctrl: RTL and testbench
=======================================

Name: midi_mono_voice_ctrl

Overview:
- Upstream stage of the note/pitch-to-DDS converter.
- Consumes the received MIDI byte stream from the UART receiver and decodes Note On/Off, Pitch Bend and All Notes Off for one channel.
- Maintains a last-note-priority note stack for monophonic playing.
- Drives NOTE and PITCH straight into the note/pitch-to-DDS block, plus GATE/VELOCITY/retrigger for the envelope.

Parameters:
- CHANNEL, 0, MIDI channel nibble (0..15) the block responds to.
- STACK_DEPTH, 8, number of held notes remembered (2..16).

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous, active-high reset.
- RX_DATA  input  8  received MIDI byte.
- RX_VALID  input  1  one-cycle strobe; RX_DATA valid. Strobes may arrive back-to-back.
- NOTE  output  7  current note number (top of stack).
- PITCH  output  14  pitch bend value; 8192 = centre.
- VELOCITY  output  7  velocity of the note currently on top of the stack.
- GATE  output  1  high while the stack is non-empty.
- NOTE_ON_STB  output  1  one-cycle pulse when a note is pushed (retrigger).

Behaviour:
- Interface: one clock (CLK). Reset is asynchronous and active-high (RST).
- Reset values: NOTE=0, PITCH=14'd8192, VELOCITY=0, GATE=0, NOTE_ON_STB=0. Stack empty, parser in IDLE, running status cleared. Reset mid-message discards any partial message.
- Parser FSM states: IDLE, DATA1, DATA2.
  - Byte 0xF8..0xFF (realtime): ignored completely; state, running status and held data unchanged.
  - Byte 0xF0..0xF7: clears running status, go to IDLE. Following data bytes (e.g. SysEx) are ignored until the next status byte.
  - Byte 0x80..0xEF: latched as running status, go to DATA1. Status bytes always abort any partial message.
  - Data byte in IDLE: ignored.
  - Data byte in DATA1: store d1. For two-byte messages (0x8n, 0x9n, 0xBn, 0xEn) go to DATA2. For 0xCn/0xDn the message completes here; return to DATA1.
  - Data byte in DATA2: message complete; return to DATA1 (running status).
- Channel filter: complete messages whose channel is not CHANNEL are consumed but produce no command.
- Commands issued on message completion:
  - 0x9n with velocity>0: NOTE_ON.
  - 0x8n, or 0x9n with velocity=0: NOTE_OFF.
  - 0xBn with d1=123: ALL_OFF. All other controllers are ignored.
  - 0xEn: PITCH <= {d2, d1}, updated atomically. No intermediate PITCH value is ever visible.
  - 0xCn, 0xDn: no command.
- Latency: the command is registered on the RX_VALID cycle of the final data byte. Stack and outputs update on the next edge, so outputs reflect the message 2 clocks after the final strobe edge. Back-to-back commands are applied in order.
- Stack rules (entries are {note, velocity}):
  - NOTE_ON of a note already held: remove the existing entry, compact, then push on top.
  - NOTE_ON when full: drop the bottom (oldest) entry, then push.
  - NOTE_OFF: remove the matching entry and compact. A note not held is a no-op.
  - ALL_OFF: empty the stack.
  - Each stack operation completes in one cycle.
- Outputs:
  - NOTE/VELOCITY follow the top of the stack.
  - When the stack empties, NOTE/VELOCITY hold their last values and GATE falls. This gives the release tail.
  - NOTE_ON_STB pulses for exactly one cycle, coincident with the NOTE update, for every NOTE_ON, including re-press of a held note.
  - No pulse on NOTE_OFF, even when an older note is uncovered.

Optional Feature:
- MIDI_OMNI_EN defined: the channel filter is disabled and messages on all 16 channels are accepted.
- MIDI_OMNI_EN undefined: only CHANNEL is accepted.

Decomposition:
- Package midi_pkg holds:
  - status nibble constants: ST_NOTE_OFF=4'h8, ST_NOTE_ON=4'h9, ST_CC=4'hB, ST_PGM=4'hC, ST_CHPRESS=4'hD, ST_PBEND=4'hE;
  - CC_ALL_NOTES_OFF=7'd123;
  - PITCH_CENTER=14'd8192;
  - the parser state encoding and the command encoding (NONE/ON/OFF/ALL_OFF).
- Sub-module midi_note_stack (parameter STACK_DEPTH): takes cmd, note, velocity; outputs top note, top velocity, non-empty flag and push pulse.

Test Plan:
- Reset released -> NOTE=0, PITCH=8192, GATE=0. Send 90 3C 64 -> 2 clocks after the last strobe: NOTE=60, VELOCITY=100, GATE=1, one NOTE_ON_STB pulse.
- 90 3C 64, then running-status 40 50, then 3C 00 -> NOTE=64 while both are held. After 3C 00: NOTE=64, GATE=1. Then 80 40 00 -> GATE=0, NOTE stays 64.
- E0 00 60 -> PITCH=12288. E0 7F 7F -> PITCH=16383. Insert F8 between LSB and MSB -> identical result; PITCH unchanged until the MSB arrives.
- Press notes 50..58 (9 notes, STACK_DEPTH=8), then release 58..51 -> NOTE walks back down 57..51 and GATE falls after releasing 51. Note 50 was dropped and never reappears.
- 91 3C 64 with CHANNEL=0 -> no change (with MIDI_OMNI_EN: NOTE=60, GATE=1). B0 7B 00 while 3 notes held -> GATE=0 next cycle.
- Assert RST between 90 and 3C -> outputs at reset values. A following 3C 64 without a new status byte is ignored.

Source files
------------

// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared MIDI status/command encodings for the mono voice controller
package midi_pkg;
   localparam logic [3:0]  ST_NOTE_OFF      = 4'h8;
   localparam logic [3:0]  ST_NOTE_ON       = 4'h9;
   localparam logic [3:0]  ST_CC            = 4'hB;
   localparam logic [3:0]  ST_PGM           = 4'hC;
   localparam logic [3:0]  ST_CHPRESS       = 4'hD;
   localparam logic [3:0]  ST_PBEND         = 4'hE;
   localparam logic [6:0]  CC_ALL_NOTES_OFF = 7'd123;
   localparam logic [13:0] PITCH_CENTER     = 14'd8192;

   typedef enum logic [1:0] {P_IDLE, P_DATA1, P_DATA2} parse_state_t;
   typedef enum logic [1:0] {CMD_NONE, CMD_ON, CMD_OFF, CMD_ALL_OFF} cmd_t;
endpackage

// File: rtl/midi_note_stack.sv
// rtl/midi_note_stack.sv - last-note-priority held-note stack, one command per cycle
module midi_note_stack
   import midi_pkg::*;
#(
   parameter int STACK_DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] cmd,
   input  logic [6:0] note,
   input  logic [6:0] velocity,
   output logic [6:0] top_note,
   output logic [6:0] top_velocity,
   output logic       non_empty,
   output logic       push
);
   localparam int CW = $clog2(STACK_DEPTH + 1);

   // index 0 is the oldest entry; count-1 is the top
   logic [6:0]    st_note  [STACK_DEPTH];
   logic [6:0]    st_vel   [STACK_DEPTH];
   logic [6:0]    ext_note [STACK_DEPTH+1];
   logic [6:0]    ext_vel  [STACK_DEPTH+1];
   logic [6:0]    rm_note  [STACK_DEPTH+1];
   logic [6:0]    rm_vel   [STACK_DEPTH+1];
   logic [6:0]    nx_note  [STACK_DEPTH];
   logic [6:0]    nx_vel   [STACK_DEPTH];
   logic [CW-1:0] count, rm_count, nx_count, base;
   logic [6:0]    nx_top_note, nx_top_vel;
   logic          hit, full;

   always_comb begin
      hit = 1'b0;
      ext_note[STACK_DEPTH] = '0;
      ext_vel[STACK_DEPTH]  = '0;
      rm_note[STACK_DEPTH]  = '0;
      rm_vel[STACK_DEPTH]   = '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
         ext_note[i] = st_note[i];
         ext_vel[i]  = st_vel[i];
      end
      // pull everything above a matching entry down one slot
      for (int i = 0; i < STACK_DEPTH; i++) begin
         if (CW'(i) < count && st_note[i] == note) hit = 1'b1;
         rm_note[i] = hit ? ext_note[i+1] : ext_note[i];
         rm_vel[i]  = hit ? ext_vel[i+1]  : ext_vel[i];
      end
      rm_count = hit ? count - CW'(1) : count;
      full     = rm_count == CW'(STACK_DEPTH);
      base     = full ? rm_count - CW'(1) : rm_count;

      nx_count = count;
      for (int i = 0; i < STACK_DEPTH; i++) begin
         nx_note[i] = st_note[i];
         nx_vel[i]  = st_vel[i];
      end
      case (cmd)
         CMD_ON: begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
               nx_note[i] = full ? rm_note[i+1] : rm_note[i];
               nx_vel[i]  = full ? rm_vel[i+1]  : rm_vel[i];
               if (CW'(i) == base) begin
                  nx_note[i] = note;
                  nx_vel[i]  = velocity;
               end
            end
            nx_count = base + CW'(1);
         end
         CMD_OFF: begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
               nx_note[i] = rm_note[i];
               nx_vel[i]  = rm_vel[i];
            end
            nx_count = rm_count;
         end
         CMD_ALL_OFF: nx_count = '0;
         default: ;
      endcase

      nx_top_note = '0;
      nx_top_vel  = '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
         if (CW'(i + 1) == nx_count) begin
            nx_top_note = nx_note[i];
            nx_top_vel  = nx_vel[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < STACK_DEPTH; i++) begin
            st_note[i] <= '0;
            st_vel[i]  <= '0;
         end
         count        <= '0;
         top_note     <= '0;
         top_velocity <= '0;
         push         <= 1'b0;
      end else begin
         for (int i = 0; i < STACK_DEPTH; i++) begin
            st_note[i] <= nx_note[i];
            st_vel[i]  <= nx_vel[i];
         end
         count <= nx_count;
         // an emptied stack keeps the last note/velocity for the release tail
         if (nx_count != '0) begin
            top_note     <= nx_top_note;
            top_velocity <= nx_top_vel;
         end
         push <= cmd == CMD_ON;
      end
   end

   assign non_empty = count != '0;
endmodule

// File: rtl/midi_mono_voice_ctrl.sv
// rtl/midi_mono_voice_ctrl.sv - MIDI byte parser and mono voice control; MIDI_OMNI_EN accepts all channels
module midi_mono_voice_ctrl
   import midi_pkg::*;
#(
   parameter int CHANNEL     = 0,
   parameter int STACK_DEPTH = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [7:0]  RX_DATA,
   input  logic        RX_VALID,
   output logic [6:0]  NOTE,
   output logic [13:0] PITCH,
   output logic [6:0]  VELOCITY,
   output logic        GATE,
   output logic        NOTE_ON_STB
);
   parse_state_t state, state_n;
   logic [7:0]   status, status_n;
   logic [6:0]   d1, d1_n;
   logic         msg_done, ch_ok, pb_n, pb_q;
   cmd_t         cmd_n, cmd_q;
   logic [6:0]   cmd_note, cmd_vel;
   logic [13:0]  pb_val;

`ifdef MIDI_OMNI_EN
   assign ch_ok = 1'b1;
`else
   assign ch_ok = status[3:0] == CHANNEL[3:0];
`endif

   always_comb begin
      state_n  = state;
      status_n = status;
      d1_n     = d1;
      msg_done = 1'b0;
      if (RX_VALID && RX_DATA[7:3] != 5'b11111) begin
         if (RX_DATA[7:4] == 4'hF) begin
            state_n  = P_IDLE;
            status_n = '0;
         end else if (RX_DATA[7]) begin
            state_n  = P_DATA1;
            status_n = RX_DATA;
         end else begin
            case (state)
               P_DATA1: begin
                  d1_n = RX_DATA[6:0];
                  if (status[7:4] == ST_PGM || status[7:4] == ST_CHPRESS) msg_done = 1'b1;
                  else state_n = P_DATA2;
               end
               P_DATA2: begin
                  msg_done = 1'b1;
                  state_n  = P_DATA1;
               end
               default: ;
            endcase
         end
      end

      cmd_n = CMD_NONE;
      pb_n  = 1'b0;
      if (msg_done && ch_ok) begin
         case (status[7:4])
            ST_NOTE_ON:  cmd_n = (RX_DATA[6:0] != '0) ? CMD_ON : CMD_OFF;
            ST_NOTE_OFF: cmd_n = CMD_OFF;
            ST_CC:       if (d1 == CC_ALL_NOTES_OFF) cmd_n = CMD_ALL_OFF;
            ST_PBEND:    pb_n = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= P_IDLE;
         status   <= '0;
         d1       <= '0;
         cmd_q    <= CMD_NONE;
         cmd_note <= '0;
         cmd_vel  <= '0;
         pb_q     <= 1'b0;
         pb_val   <= PITCH_CENTER;
         PITCH    <= PITCH_CENTER;
      end else begin
         state    <= state_n;
         status   <= status_n;
         d1       <= d1_n;
         cmd_q    <= cmd_n;
         cmd_note <= d1;
         cmd_vel  <= RX_DATA[6:0];
         pb_q     <= pb_n;
         if (pb_n) pb_val <= {RX_DATA[6:0], d1};
         // whole 14-bit word moves together, aligned with the stack update
         if (pb_q) PITCH <= pb_val;
      end
   end

   midi_note_stack #(.STACK_DEPTH(STACK_DEPTH)) u_stack (
      .clk          (CLK),
      .rst          (RST),
      .cmd          (cmd_q),
      .note         (cmd_note),
      .velocity     (cmd_vel),
      .top_note     (NOTE),
      .top_velocity (VELOCITY),
      .non_empty    (GATE),
      .push         (NOTE_ON_STB)
   );
endmodule

// File: tb/tb_midi_mono_voice_ctrl.sv
// tb/tb_midi_mono_voice_ctrl.sv - randomized bench against a queue-based MIDI voice model
module tb_midi_mono_voice_ctrl;
   localparam int DEPTH = 8;
`ifdef MIDI_OMNI_EN
   localparam bit OMNI = 1'b1;
`else
   localparam bit OMNI = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [7:0]  RX_DATA = '0;
   logic        RX_VALID = 1'b0;
   logic [6:0]  NOTE, VELOCITY;
   logic [13:0] PITCH;
   logic        GATE, NOTE_ON_STB;

   int n_tests = 0;
   int n_fail  = 0;
   int got_pulses = 0;

   int m_status = -1;
   int m_need, m_have;
   int m_d [2];
   int stk [$];
   int exp_note = 0, exp_vel = 0, exp_pitch = 8192, exp_pulses = 0;

   always #5 CLK = ~CLK;

   midi_mono_voice_ctrl #(.CHANNEL(0), .STACK_DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
      .NOTE(NOTE), .PITCH(PITCH), .VELOCITY(VELOCITY), .GATE(GATE),
      .NOTE_ON_STB(NOTE_ON_STB)
   );

   always @(negedge CLK) if (NOTE_ON_STB === 1'b1) got_pulses++;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic void m_refresh();
      if (stk.size() > 0) begin
         exp_note = stk[stk.size()-1] / 128;
         exp_vel  = stk[stk.size()-1] % 128;
      end
   endfunction

   function automatic void m_remove(int n);
      for (int i = 0; i < stk.size(); i++)
         if (stk[i] / 128 == n) begin
            stk.delete(i);
            break;
         end
   endfunction

   function automatic void m_msg();
      int kind = m_status / 16;
      if (!OMNI && (m_status % 16) != 0) return;
      case (kind)
         9, 8: begin
            m_remove(m_d[0]);
            if (kind == 9 && m_d[1] > 0) begin
               if (stk.size() == DEPTH) stk.delete(0);
               stk.push_back(m_d[0] * 128 + m_d[1]);
               exp_pulses++;
            end
            m_refresh();
         end
         11: if (m_d[0] == 123) stk.delete();
         14: exp_pitch = m_d[1] * 128 + m_d[0];
         default: ;
      endcase
   endfunction

   function automatic void m_byte(int b);
      if (b >= 'hF8) return;
      if (b >= 'hF0) begin
         m_status = -1;
         return;
      end
      if (b >= 'h80) begin
         m_status = b;
         m_have   = 0;
         m_need   = (b / 16 == 12 || b / 16 == 13) ? 1 : 2;
         return;
      end
      if (m_status < 0) return;
      m_d[m_have] = b;
      m_have++;
      if (m_have == m_need) begin
         m_have = 0;
         m_msg();
      end
   endfunction

   function automatic void m_reset();
      m_status  = -1;
      m_have    = 0;
      stk.delete();
      exp_note  = 0;
      exp_vel   = 0;
      exp_pitch = 8192;
   endfunction

   task automatic send(input int b);
      @(negedge CLK);
      RX_DATA  = 8'(b);
      RX_VALID = 1'b1;
      m_byte(b);
   endtask

   task automatic idle(input int n);
      @(negedge CLK);
      RX_VALID = 1'b0;
      repeat (n - 1) @(negedge CLK);
   endtask

   task automatic settle(input string tag);
      idle(4);
      check_eq({tag, ".note"},   NOTE,       exp_note);
      check_eq({tag, ".vel"},    VELOCITY,   exp_vel);
      check_eq({tag, ".gate"},   GATE,       (stk.size() > 0) ? 1 : 0);
      check_eq({tag, ".pitch"},  PITCH,      exp_pitch);
      check_eq({tag, ".pulses"}, got_pulses, exp_pulses);
   endtask

   initial begin
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      check_eq("rst.stb", NOTE_ON_STB, 0);
      settle("reset");
      check_eq("reset.pitch_const", PITCH, 8192);

      // first note: exact two-edge latency and single strobe
      send('h90); send('h3C); send('h64);
      @(negedge CLK);
      RX_VALID = 1'b0;
      check_eq("lat.early_gate", GATE, 0);
      check_eq("lat.early_stb", NOTE_ON_STB, 0);
      @(negedge CLK);
      check_eq("lat.note", NOTE, 60);
      check_eq("lat.vel", VELOCITY, 100);
      check_eq("lat.gate", GATE, 1);
      check_eq("lat.stb", NOTE_ON_STB, 1);
      @(negedge CLK);
      check_eq("lat.stb_end", NOTE_ON_STB, 0);
      settle("note60");

      send('h40); send('h50);
      settle("rs_on64");
      check_eq("rs_on64.const", NOTE, 64);
      send('h3C); send('h00);
      settle("rs_off60");
      check_eq("rs_off60.const", NOTE, 64);
      send('h80); send('h40); send('h00);
      settle("off64");
      check_eq("off64.gate_const", GATE, 0);
      check_eq("off64.note_const", NOTE, 64);

      send('hE0); send('h00); send('h60);
      settle("pb1");
      check_eq("pb1.const", PITCH, 12288);
      send('hE0); send('h7F); send('h7F);
      settle("pb2");
      check_eq("pb2.const", PITCH, 16383);
      send('hE0); send('h00); send('hF8);
      settle("pb_half");
      check_eq("pb_half.const", PITCH, 16383);
      send('h60);
      settle("pb3");
      check_eq("pb3.const", PITCH, 12288);

      for (int n = 50; n <= 58; n++) begin
         send('h90); send(n); send(20 + n);
      end
      settle("full");
      for (int n = 58; n >= 51; n--) begin
         send('h80); send(n); send('h40);
         settle($sformatf("rel%0d", n));
      end
      check_eq("drop.gate", GATE, 0);
      send('h80); send(50); send('h40);
      settle("rel50");

      send('h91); send('h3C); send('h64);
      settle("ch1");
      send('h90); send(61); send(1); send(62); send(2); send(63); send(3);
      settle("three");
      send('hB0); send('h7B); send('h00);
      settle("alloff");

      send('h90);
      @(negedge CLK);
      RX_VALID = 1'b0;
      RST = 1'b1;
      #2;
      m_reset();
      check_eq("mrst.note", NOTE, 0);
      check_eq("mrst.gate", GATE, 0);
      check_eq("mrst.pitch", PITCH, 8192);
      @(negedge CLK);
      RST = 1'b0;
      send('h3C); send('h64);
      settle("mrst_after");

      for (int it = 0; it < 400; it++) begin
         int r  = $urandom_range(0, 99);
         int ch = ($urandom_range(0, 9) == 0) ? 1 : 0;
         if (r < 30) begin
            if ($urandom_range(0, 1) == 1) send('h90 + ch);
            send(40 + $urandom_range(0, 11));
            send(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 127));
         end else if (r < 50) begin
            if ($urandom_range(0, 1) == 1) send('h80 + ch);
            send(40 + $urandom_range(0, 11));
            send($urandom_range(0, 127));
         end else if (r < 58) begin
            send('hB0 + ch);
            send(($urandom_range(0, 1) == 1) ? 123 : $urandom_range(0, 127));
            send(0);
         end else if (r < 70) begin
            send('hE0 + ch);
            send($urandom_range(0, 127));
            if ($urandom_range(0, 2) == 0) send('hF8 + $urandom_range(0, 7));
            send($urandom_range(0, 127));
         end else if (r < 75) begin
            send('hF8 + $urandom_range(0, 7));
         end else if (r < 78) begin
            send('hF0 + $urandom_range(0, 7));
            send($urandom_range(0, 127));
            send($urandom_range(0, 127));
         end else if (r < 85) begin
            send('hC0 + ch);
            send($urandom_range(0, 127));
         end else begin
            send($urandom_range(0, 127));
         end
         if ($urandom_range(0, 3) == 0) settle($sformatf("rnd%0d", it));
      end
      settle("final");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
